rr_burst_arbiter: RTL
=====================

Name: rr_burst_arbiter

Overview:
- Parametrised successor to the fixed-policy round-robin FIFO arbiter that merges the TLU, timestamp and front-end FIFO streams into the single readout FIFO.
- Adds configurable channel count and data width, a burst limit per grant, a hold with timeout, runtime channel masking, an optional strict-priority channel 0, and a granted-channel ID output.
- Sits between the per-source first-word-fall-through FIFOs and the readout FIFO write port, and runs on the bus clock.

Parameters:
WIDTH, 8, number of requesting channels (2..16)
DATA_WIDTH, 32, word width per channel
MAX_BURST, 16, maximum words per grant before rotating; 0 = unlimited
HOLD_TIMEOUT, 64, idle cycles a held grant may persist with no data before it is forcibly released; 0 = never
STRICT0, 0, 1 = channel 0 preempts the rotation at every arbitration point

Ports:
CLK  in  1  single clock (bus clock domain)
nRST  in  1  synchronous, active-low reset
WRITE_REQ  in  WIDTH  channel i has a word available (~FIFO_EMPTY)
HOLD_REQ  in  WIDTH  channel i requests to keep its grant
CH_ENABLE  in  WIDTH  runtime mask; 0 = channel is never granted
DATA_IN  in  WIDTH*DATA_WIDTH  channel i word at bits [i*DATA_WIDTH +: DATA_WIDTH], first-word-fall-through
READ_GRANT  out  WIDTH  one-hot FIFO read strobe
READY_OUT  in  1  downstream can accept a word this cycle
WRITE_OUT  out  1  DATA_OUT valid (write strobe)
DATA_OUT  out  DATA_WIDTH  registered output word
GRANT_ID  out  clog2(WIDTH)  current owner index; valid while BUSY=1
BUSY  out  1  a grant is active

Behaviour:
- Reset (nRST=0 at a CLK edge):
  - WRITE_OUT=0, DATA_OUT=0, READ_GRANT=0, BUSY=0, GRANT_ID=0.
  - Burst and timeout counters are cleared.
  - The last-served pointer is set to WIDTH-1, so the first search starts at channel 0.
  - A grant in progress is abandoned with no partial write.
- States: IDLE, GRANT.
- IDLE:
  - Eligible channels are req[i] = WRITE_REQ[i] & CH_ENABLE[i].
  - If STRICT0=1 and req[0]=1, the owner is 0. Otherwise the owner is the first eligible channel searching from last+1 upward, wrapping modulo WIDTH.
  - If any channel is eligible: register the owner into GRANT_ID, set BUSY=1, clear the counters, go to GRANT. Choosing an owner costs one cycle with no read.
  - If no channel is eligible: stay in IDLE.
- GRANT, combinational read:
  - READ_GRANT[owner] = READY_OUT & WRITE_REQ[owner] & CH_ENABLE[owner] & (burst_cnt < MAX_BURST or MAX_BURST=0 or HOLD_REQ[owner]).
  - READ_GRANT is never asserted outside GRANT and is never multi-hot.
- Output latency:
  - On a cycle with READ_GRANT[owner]=1: next edge DATA_OUT <= DATA_IN[owner] and WRITE_OUT <= 1.
  - Otherwise WRITE_OUT <= 0 and DATA_OUT holds its value. Latency is exactly one cycle.
- Counters:
  - burst_cnt increments on each read and saturates at MAX_BURST.
  - idle_cnt increments on GRANT cycles with no read, resets to 0 on any read, and saturates at HOLD_TIMEOUT.
- Release from GRANT back to IDLE (registered; the cycle after release is IDLE). Any one of:
  - (a) CH_ENABLE[owner]=0;
  - (b) WRITE_REQ[owner]=0 and HOLD_REQ[owner]=0;
  - (c) MAX_BURST≠0, burst_cnt=MAX_BURST and HOLD_REQ[owner]=0;
  - (d) HOLD_TIMEOUT≠0 and idle_cnt=HOLD_TIMEOUT.
- On release: last <= owner and BUSY <= 0.
- STRICT0 applies only at arbitration points; channel 0 never interrupts a running grant.
- READY_OUT low during GRANT: no reads; idle_cnt advances only if HOLD_REQ[owner]=1. Backpressure alone never releases a grant, never triggers a timeout, and never drops data.
- HOLD_REQ overrides the burst limit but not the timeout or CH_ENABLE.
- Simultaneous release condition and read in the same cycle: the read completes, and the release takes effect at the same edge.
- Word ordering within a channel is preserved. No word is read without a WRITE_OUT one cycle later.

Test Plan:
- WIDTH=4, MAX_BURST=2; channels 0..3 each preload 3 words, READY_OUT=1. Required output order: ch0 ×2, ch1 ×2, ch2 ×2, ch3 ×2, ch0, ch1, ch2, ch3. Required timing: exactly one idle arbitration cycle between grants; WRITE_OUT follows each READ_GRANT by 1 cycle.
- Channel 2 with HOLD_REQ=1 and 40 words, MAX_BURST=16. Required: all 40 words are issued contiguously before channel 3 (also requesting) is served.
- HOLD_TIMEOUT=64; channel 1 holds with an empty FIFO. Required: release exactly 64 cycles after the last read; channel 3 is then granted.
- READY_OUT toggles 1,0,0,1 during a burst. Required: READ_GRANT only on READY_OUT=1 cycles, no duplicated or lost words, BUSY stays 1, no release.
- STRICT0=1; channels 0 and 3 request while channel 3 is mid-burst. Required: channel 3 completes its burst, then channel 0 is granted ahead of channels 1 and 2.
- nRST=0 mid-burst, and CH_ENABLE[1]=0 while channel 1 requests. Required: all outputs return to 0 next edge; after reset the first grant goes to channel 0; channel 1 is never granted.

Source files
------------

// File: rtl/rr_burst_arbiter.sv
// Round-robin burst arbiter: merges WIDTH first-word-fall-through FIFO streams into one
// registered write port, with burst limit, hold with timeout, channel mask and optional strict channel 0.
module rr_burst_arbiter #(
    parameter int WIDTH        = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_BURST    = 16,
    parameter int HOLD_TIMEOUT = 64,
    parameter int STRICT0      = 0
) (
    input  logic                          CLK,
    input  logic                          nRST,
    input  logic [WIDTH-1:0]              WRITE_REQ,
    input  logic [WIDTH-1:0]              HOLD_REQ,
    input  logic [WIDTH-1:0]              CH_ENABLE,
    input  logic [WIDTH*DATA_WIDTH-1:0]   DATA_IN,
    output logic [WIDTH-1:0]              READ_GRANT,
    input  logic                          READY_OUT,
    output logic                          WRITE_OUT,
    output logic [DATA_WIDTH-1:0]         DATA_OUT,
    output logic [$clog2(WIDTH)-1:0]      GRANT_ID,
    output logic                          BUSY
);

    localparam int IDW = $clog2(WIDTH);
    localparam int BW  = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam int TW  = (HOLD_TIMEOUT > 0) ? $clog2(HOLD_TIMEOUT + 1) : 1;
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
    localparam logic [TW-1:0] TMO_MAX   = TW'(HOLD_TIMEOUT);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                  state_q, state_d;
    logic [IDW-1:0]          owner_q, owner_d;
    logic [IDW-1:0]          last_q, last_d;
    logic                    busy_q, busy_d;
    logic [BW-1:0]           burst_q, burst_d;
    logic [TW-1:0]           idle_q, idle_d;
    logic                    wr_q;
    logic [DATA_WIDTH-1:0]   data_q;

    logic [WIDTH-1:0]        req;
    logic [IDW-1:0]          pick, idx;
    logic                    found;
    logic                    own_req, own_en, own_hold;
    logic                    burst_ok, rd, rel;
    logic [DATA_WIDTH-1:0]   own_word;

    // Rotating search starts one past the last served channel.
    always_comb begin
        req   = WRITE_REQ & CH_ENABLE;
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= WIDTH; k++) begin
            idx = IDW'((int'(last_q) + k) % WIDTH);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        if (STRICT0 != 0 && req[0])
            pick = '0;
    end

    always_comb begin
        own_req  = WRITE_REQ[owner_q];
        own_en   = CH_ENABLE[owner_q];
        own_hold = HOLD_REQ[owner_q];
        own_word = DATA_IN[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
        burst_ok = (MAX_BURST == 0) || (burst_q < BURST_MAX) || own_hold;
        // Gated by nRST so a word is never popped on the edge that discards it.
        rd       = (state_q == GRANT) && nRST && READY_OUT && own_req && own_en && burst_ok;
        rel      = (state_q == GRANT) &&
                   (!own_en ||
                    (!own_req && !own_hold) ||
                    (MAX_BURST != 0 && burst_q == BURST_MAX && !own_hold) ||
                    (HOLD_TIMEOUT != 0 && idle_q == TMO_MAX));
        READ_GRANT          = '0;
        READ_GRANT[owner_q] = rd;
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        busy_d  = busy_q;
        burst_d = burst_q;
        idle_d  = idle_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    owner_d = pick;
                    busy_d  = 1'b1;
                    burst_d = '0;
                    idle_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (rd) begin
                    idle_d = '0;
                    if (!(MAX_BURST != 0 && burst_q == BURST_MAX))
                        burst_d = burst_q + 1'b1;
                end else if (READY_OUT || own_hold) begin
                    // Pure backpressure without a hold does not age the grant.
                    if (!(HOLD_TIMEOUT != 0 && idle_q == TMO_MAX))
                        idle_d = idle_q + 1'b1;
                end
                if (rel) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IDW'(WIDTH - 1);
            busy_q  <= 1'b0;
            burst_q <= '0;
            idle_q  <= '0;
            wr_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            burst_q <= burst_d;
            idle_q  <= idle_d;
            wr_q    <= rd;
            if (rd)
                data_q <= own_word;
        end
    end

    assign WRITE_OUT = wr_q;
    assign DATA_OUT  = data_q;
    assign GRANT_ID  = owner_q;
    assign BUSY      = busy_q;

endmodule
